fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the CDC FIFO (write_enable/write_data/full) among NUM_REQ write-domain requesters.
- Grants one requester at a time for a burst of up to MAX_BURST beats, then rotates priority.
- Sits entirely in the write clock domain, directly in front of the FIFO write port; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, payload width; matches the FIFO write_data width.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255).
- CNT_WIDTH, 16, width of each per-requester statistics counter (used only with ARB_STATS_EN).

Ports:
- write_clk  in  1  write-domain clock; all logic on rising edge.
- write_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  beat is the last of the requester's burst.
- req_ready  out  NUM_REQ  beat accepted this cycle (valid & ready = transfer).
- write_enable  out  1  FIFO write strobe.
- write_data  out  DATA_WIDTH  FIFO write payload.
- full  in  1  FIFO full flag (write domain).
- grant_id  out  $clog2(NUM_REQ)  index of current owner; 0 when idle.
- busy  out  1  high in BUSY state.
- beat_count  out  NUM_REQ*CNT_WIDTH  accepted-beat counters (ARB_STATS_EN only).

Behaviour:
- Reset (write_rst=1 at an edge):
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - Outputs while reset is asserted: req_ready=0, write_enable=0, write_data=0, grant_id=0, busy=0.
  - A reset mid-burst aborts the burst. No write is issued in any cycle where write_rst=1 (write_enable combinationally gated by ~write_rst).
- FSM states are IDLE and BUSY.
- IDLE:
  - req_ready=0, write_enable=0.
  - If any req_valid is set: owner <= first set index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ; burst_cnt <= 0; go to BUSY.
  - Arbitration costs exactly one cycle. The first beat can transfer in the cycle after a valid is first seen.
- BUSY:
  - req_ready[owner] = ~full; all other req_ready bits = 0.
  - write_enable = req_valid[owner] & ~full.
  - write_data = req_data[owner] when BUSY, else 0.
  - Outputs are combinational from registered owner/state; there is no pipeline latency to the FIFO.
  - On each transfer, burst_cnt increments.
- Release: on a transfer where req_last[owner]=1 OR burst_cnt+1 == MAX_BURST:
  - go to IDLE; rr_ptr <= (owner+1) mod NUM_REQ; burst_cnt <= 0.
- Owner drops valid: if req_valid[owner]=0 for a BUSY cycle without release, the owner keeps the grant (no preemption). Requesters must hold valid through the burst.
- full=1: no transfer and no state change. burst_cnt holds. A stall of any length is legal.
- Requester handshake rule: data, valid and last stay stable while valid=1 and ready=0.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins.
- rr_ptr wraps from NUM_REQ-1 to 0.
- busy = (state==BUSY). grant_id = owner in BUSY, 0 in IDLE.
- Guaranteed bandwidth: worst-case wait for any valid requester is (NUM_REQ-1)*(MAX_BURST+1) non-full cycles.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - One CNT_WIDTH counter per requester, incremented on each of that requester's transfers.
  - Counters saturate at all-ones (no wrap) and clear on write_rst.
  - Driven on beat_count.
- Undefined:
  - No counters are synthesised; beat_count is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset: hold write_rst=1 for 3 cycles with all req_valid=1 -> write_enable=0, req_ready=0, busy=0 every cycle; first grant goes to req 0 one cycle after release.
- Single requester: req 2 sends 0x01..0x03 with last on 0x03, full=0 -> grant_id=2; FIFO receives 01, 02, 03 on 3 consecutive cycles; then IDLE, rr_ptr=3.
- Round-robin with forced rotation: reqs 0 and 1 stream continuously, MAX_BURST=4 -> FIFO sequence is 4 beats from req 0, 1 idle cycle, 4 beats from req 1, 1 idle cycle, then req 0 again.
- Full back-pressure: full=1 mid-burst after 2 beats for 5 cycles -> write_enable=0 and req_ready=0 throughout; burst resumes with beat 3; release still occurs after 4 total beats.
- Reset mid-burst: assert write_rst after beat 1 of req 3 -> no write that cycle; state=IDLE, rr_ptr=0; with reqs 1 and 3 still valid, req 1 wins next.
- ARB_STATS_EN with CNT_WIDTH=4: req 0 transfers 20 beats -> beat_count slice 0 reads 15 (saturated); other slices read 0; write_rst clears all slices to 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester and FIFO write-port bundle for fifo_write_arbiter
//
// Purpose: groups the per-requester beat handshake and the single FIFO write
// port that fifo_write_arbiter sits between.
//
// Signals:
//   req_valid    [NUM_REQ]             per-requester beat valid
//   req_data     [NUM_REQ*DATA_WIDTH]  per-requester payload, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     [NUM_REQ]             beat is the last of the requester's burst
//   req_ready    [NUM_REQ]             beat accepted this cycle (valid & ready = transfer)
//   write_enable                       FIFO write strobe
//   write_data   [DATA_WIDTH]          FIFO write payload
//   full                               FIFO full flag (write domain)
//
// Modports:
//   master - requesters and FIFO side (drives requests and full)
//   slave  - arbiter side (drives ready and the FIFO write port)
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          write_enable;
  logic [DATA_WIDTH-1:0]         write_data;
  logic                          full;

  modport master (
    output req_valid, req_data, req_last, full,
    input  req_ready, write_enable, write_data
  );

  modport slave (
    input  req_valid, req_data, req_last, full,
    output req_ready, write_enable, write_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ requesters
//
// Purpose: grants one write-domain requester at a time for a burst of up to
// MAX_BURST beats, then rotates priority. One idle arbitration cycle precedes
// each grant; beats pass combinationally to the FIFO write port.
//
// Optional feature macro: ARB_STATS_EN (per-requester saturating beat counters
// on beat_count; when undefined beat_count is tied to 0).
//
// Ports:
//   write_clk   in   write-domain clock, rising edge
//   write_rst   in   synchronous active-high reset
//   bus         if   fifo_write_arbiter_if.slave (requests in, FIFO write port out)
//   grant_id    out  current owner in BUSY, 0 otherwise
//   busy        out  high while a grant is held
//   beat_count  out  NUM_REQ x CNT_WIDTH accepted-beat counters
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         write_clk,
  input  logic                         write_rst,
  fifo_write_arbiter_if.slave          bus,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0] beat_count
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic            any_valid;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            is_busy;
  logic            owner_valid;
  logic            owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic            transfer;
  logic            last_beat;
  logic            release_burst;

  assign any_valid = |bus.req_valid;

  // Rotating priority search: first valid index at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  always_comb begin
    int s;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      cand = IDW'(s);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign owner_data  = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  // Everything visible is gated by reset so nothing leaks out during a reset
  // cycle even though the registers only clear at the edge.
  assign is_busy  = (state_q == BUSY) && !write_rst;
  assign transfer = is_busy && owner_valid && !bus.full;

  assign last_beat     = ({1'b0, burst_cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign release_burst = transfer && (owner_last || last_beat);

  always_comb begin
    bus.req_ready = '0;
    if (is_busy && !bus.full) bus.req_ready[owner_q] = 1'b1;
  end

  assign bus.write_enable = transfer;
  assign bus.write_data   = is_busy ? owner_data : '0;
  assign grant_id         = is_busy ? owner_q : '0;
  assign busy             = is_busy;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // full stalls everything: no transfer means no state change.
        if (transfer) begin
          if (release_burst) begin
            state_d     = IDLE;
            rr_ptr_d    = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (transfer && (owner_q == IDW'(i)) && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    beat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) beat_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 4;
`ifdef ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N*CW-1:0] beat_count;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .write_clk (clk),
    .write_rst (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_count(beat_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, where priority starts, beats taken.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_cnt [N];

  logic          s_we;
  logic [DW-1:0] s_wdata;
  logic [N-1:0]  s_ready;
  logic [1:0]    s_grant;
  logic          s_busy;
  logic [DW-1:0] wq[$];
  logic [3:0]    beatn [N];

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          full;
    logic [N*DW-1:0] data;
    logic          we;
    logic [N-1:0]  ready;
    logic [1:0]    grant;
    logic          bsy;
    logic [DW-1:0] wdata;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic          e_busy;
    int            e_grant;
    logic [N-1:0]  e_ready;
    logic          e_we;
    logic [DW-1:0] e_wdata;
    logic [N*CW-1:0] e_cnt;
    bit            hit;
    int            idx;
    @(negedge clk);
    e_busy  = !rst && m_busy;
    e_grant = e_busy ? m_owner : 0;
    e_ready = '0;
    if (e_busy && !bus.full) e_ready[m_owner] = 1'b1;
    e_we    = e_busy && bus.req_valid[m_owner] && !bus.full;
    e_wdata = e_busy ? bus.req_data[m_owner*DW +: DW] : '0;
    e_cnt   = '0;
    if (STATS_ON) for (int i = 0; i < N; i++) e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    s_we    = bus.write_enable;
    s_wdata = bus.write_data;
    s_ready = bus.req_ready;
    s_grant = grant_id;
    s_busy  = busy;
    chk("write_enable", s_we, e_we);
    chk("write_data", s_wdata, e_wdata);
    chk("req_ready", s_ready, e_ready);
    chk("grant_id", s_grant, e_grant);
    chk("busy", s_busy, e_busy);
    chk("beat_count", beat_count, e_cnt);
    if (s_we) wq.push_back(s_wdata);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!m_busy) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!hit && bus.req_valid[idx]) begin
          hit = 1; m_owner = idx; m_busy = 1; m_beats = 0;
        end
      end
    end else if (e_we) begin
      if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
      m_beats++;
      if (bus.req_last[m_owner] || m_beats == MB) begin
        m_busy = 0; m_ptr = (m_owner + 1) % N; m_beats = 0;
      end
    end
    #1;
  endtask

  task automatic set_beats();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = {4'(i), beatn[i]};
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) if (s_ready[i] && bus.req_valid[i]) beatn[i]++;
    set_beats();
  endtask

  task automatic clear_beats();
    for (int i = 0; i < N; i++) beatn[i] = 4'd0;
    set_beats();
  endtask

  initial begin
    logic [DW-1:0] exp_a [12];
    logic [DW-1:0] exp_b [4];
    vec_t v;

    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.full = 1'b0;

    // Reset with everyone requesting, first grant to req 0, then req 2 alone
    // (01,02,03), then reqs 0 and 3 together showing rr_ptr moved to 3.
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 4'hF, 4'h1, 1'b0, 32'h000000A0, 1'b1, 4'h1, 2'd0, 1'b1, 8'hA0};
    tbl[5]  = '{1'b0, 4'h4, 4'h0, 1'b0, 32'h00010000, 1'b0, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 4'h4, 4'h0, 1'b0, 32'h00010000, 1'b1, 4'h4, 2'd2, 1'b1, 8'h01};
    tbl[7]  = '{1'b0, 4'h4, 4'h0, 1'b0, 32'h00020000, 1'b1, 4'h4, 2'd2, 1'b1, 8'h02};
    tbl[8]  = '{1'b0, 4'h4, 4'h4, 1'b0, 32'h00030000, 1'b1, 4'h4, 2'd2, 1'b1, 8'h03};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 4'h9, 4'h0, 1'b0, 32'h33000011, 1'b0, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 4'h9, 4'h9, 1'b0, 32'h33000011, 1'b1, 4'h8, 2'd3, 1'b1, 8'h33};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 4'h0, 2'd0, 1'b0, 8'h00};

    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      rst = v.rst; bus.req_valid = v.valid; bus.req_last = v.last;
      bus.full = v.full; bus.req_data = v.data;
      step();
      chk($sformatf("tbl%0d_we", i), s_we, v.we);
      chk($sformatf("tbl%0d_ready", i), s_ready, v.ready);
      chk($sformatf("tbl%0d_grant", i), s_grant, v.grant);
      chk($sformatf("tbl%0d_busy", i), s_busy, v.bsy);
      chk($sformatf("tbl%0d_wdata", i), s_wdata, v.wdata);
    end

    // Forced rotation: reqs 0 and 1 stream forever, bursts cut at MB beats.
    wq.delete(); clear_beats();
    bus.req_valid = 4'b0011; bus.req_last = '0;
    repeat (15) begin step(); advance(); end
    bus.req_valid = '0;
    exp_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
              8'h04, 8'h05, 8'h06, 8'h07};
    chk("rot_count", wq.size(), 12);
    for (int i = 0; i < 12 && i < wq.size(); i++) chk($sformatf("rot_beat%0d", i), wq[i], exp_a[i]);

    // Back-pressure after two beats; burst still ends after four beats total.
    rst = 1'b1; step(); rst = 1'b0;
    wq.delete(); clear_beats();
    bus.req_valid = 4'b0100;
    repeat (3) begin step(); advance(); end
    bus.full = 1'b1;
    repeat (5) begin
      step();
      chk("stall_we", s_we, 1'b0);
      chk("stall_ready", s_ready, 4'h0);
      advance();
    end
    bus.full = 1'b0;
    repeat (2) begin step(); advance(); end
    bus.req_valid = '0;
    step();
    chk("stall_release_busy", s_busy, 1'b0);
    exp_b = '{8'h20, 8'h21, 8'h22, 8'h23};
    chk("stall_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk($sformatf("stall_beat%0d", i), wq[i], exp_b[i]);

    // Reset in the middle of req 3's burst; req 1 wins afterwards.
    rst = 1'b1; step(); rst = 1'b0;
    clear_beats();
    bus.req_valid = 4'b1000;
    step(); advance();
    step(); advance();
    rst = 1'b1; bus.req_valid = 4'b1010;
    step();
    chk("midrst_we", s_we, 1'b0);
    chk("midrst_busy", s_busy, 1'b0);
    rst = 1'b0;
    step(); advance();
    chk("midrst_idle", s_busy, 1'b0);
    step(); advance();
    chk("midrst_grant", s_grant, 2'd1);
    chk("midrst_we1", s_we, 1'b1);
    chk("midrst_data", s_wdata, 8'h10);
    bus.req_last = 4'b0010;
    step(); advance();
    bus.req_valid = '0; bus.req_last = '0;
    step();

    // Statistics: req 0 moves 20 beats alone.
    rst = 1'b1; step(); rst = 1'b0;
    clear_beats();
    bus.req_valid = 4'b0001;
    repeat (25) begin step(); advance(); end
    bus.req_valid = '0;
    step();
    chk("stats_req0", beat_count[CW-1:0], STATS_ON ? 15 : 0);
    chk("stats_others", beat_count[N*CW-1:CW], 0);
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("stats_cleared", beat_count, 0);

    // Random traffic against the model; requesters honour the hold rule.
    for (int c = 0; c < 3000; c++) begin
      bus.full = ($urandom % 4) == 0;
      rst      = ($urandom % 200) == 0;
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i]) begin
          if (s_ready[i]) begin
            if ($urandom % 2 == 0) begin
              bus.req_data[i*DW +: DW] = DW'($urandom);
              bus.req_last[i] = ($urandom % 4) == 0;
            end else begin
              bus.req_valid[i] = 1'b0;
            end
          end
        end else if ($urandom % 3 == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*DW +: DW] = DW'($urandom);
          bus.req_last[i] = ($urandom % 4) == 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
